// File: rtl/hls_deadlock_pkg.sv
// Shared types and helpers for the HLS deadlock monitor family.
package hls_deadlock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMING  = 2'd1,
        ST_BLOCKED = 2'd2
    } dl_state_e;

    localparam int SUB_ANY        = 0;
    localparam int SUB_ALL_ACTIVE = 1;

    // Counters up to 32 bits wide share this; callers truncate to their width.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/hls_deadlock_raw_reduce.sv
// Purpose: masks axis block flags and reduces child monitor flags into raw blocked + cause vector.
// Latency: purely combinational, zero cycles.
// Backpressure: none; observes flags only.
module hls_deadlock_raw_reduce
    import hls_deadlock_pkg::*;
#(
    parameter int                   NUM_AXIS  = 3,
    parameter logic [NUM_AXIS-1:0]  AXIS_MASK = 3'b110,
    parameter int                   NUM_INST  = 3,
    parameter int                   NUM_SUB   = 1,
    parameter int                   SUB_MODE  = SUB_ANY
) (
    input  logic [NUM_AXIS-1:0]                       axis_block_sigs,
    input  logic [NUM_INST-1:0]                       inst_idle_sigs,
    input  logic [((NUM_SUB > 0) ? NUM_SUB : 1)-1:0]  inst_block_sigs,
    output logic                                      raw,
    output logic [NUM_SUB+NUM_AXIS-1:0]               cause
);

    logic [NUM_AXIS-1:0] axis_m;
    logic                axis_hit;
    logic                unused_in;

    assign axis_m    = axis_block_sigs & AXIS_MASK;
    assign axis_hit  = |axis_m;
    // Idle bits beyond NUM_SUB (and all of them in SUB_ANY mode) are intentionally ignored.
    assign unused_in = ^{inst_idle_sigs, inst_block_sigs};

    if (NUM_SUB == 0) begin : g_no_sub
        assign raw   = axis_hit;
        assign cause = axis_m;
    end else begin : g_sub
        logic [NUM_SUB-1:0] contrib;
        logic               sub_hit;

        if (SUB_MODE == SUB_ALL_ACTIVE) begin : g_all_active
            // A child counts as contributing only when it is blocked while still active.
            assign sub_hit = (&(inst_block_sigs[NUM_SUB-1:0] | inst_idle_sigs[NUM_SUB-1:0]))
                           & ~(&inst_idle_sigs[NUM_SUB-1:0]);
            assign contrib = inst_block_sigs[NUM_SUB-1:0] & ~inst_idle_sigs[NUM_SUB-1:0];
        end else begin : g_any
            assign sub_hit = |inst_block_sigs[NUM_SUB-1:0];
            assign contrib = inst_block_sigs[NUM_SUB-1:0];
        end

        assign raw   = axis_hit | sub_hit;
        assign cause = {contrib, axis_m};
    end

endmodule

// File: rtl/hls_deadlock_monitor_gen.sv
// Purpose: debounced HLS deadlock monitor with sticky flag, cause snapshot and blocked-duration counter.
// Latency: block rises THRESH edges after raw goes high, falls one edge after raw drops.
// Backpressure: none; passive observer of block/idle flags.
module hls_deadlock_monitor_gen
    import hls_deadlock_pkg::*;
#(
    parameter int                   NUM_AXIS  = 3,
    parameter logic [NUM_AXIS-1:0]  AXIS_MASK = 3'b110,
    parameter int                   NUM_INST  = 3,
    parameter int                   NUM_SUB   = 1,
    parameter int                   SUB_MODE  = SUB_ANY,
    parameter int                   THRESH    = 1,
    parameter int                   CNT_W     = 16
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [NUM_AXIS-1:0]                       axis_block_sigs,
    input  logic [NUM_INST-1:0]                       inst_idle_sigs,
    input  logic [((NUM_SUB > 0) ? NUM_SUB : 1)-1:0]  inst_block_sigs,
    input  logic                                      clear_sticky,
    output logic                                      block,
    output logic                                      block_sticky,
    output logic [NUM_SUB+NUM_AXIS-1:0]               block_cause,
    output logic [CNT_W-1:0]                          block_cycles
);

    localparam int               CAUSE_W   = NUM_SUB + NUM_AXIS;
    localparam logic [31:0]      CNT_MAX32 = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(THRESH);

    if (THRESH < 1) begin : g_err_thresh_zero
        $error("hls_deadlock_monitor_gen: THRESH must be at least 1");
    end
    if (64'(THRESH) > ((64'd1 << CNT_W) - 64'd1)) begin : g_err_thresh_big
        $error("hls_deadlock_monitor_gen: THRESH exceeds 2^CNT_W-1");
    end
    if (NUM_SUB > NUM_INST) begin : g_err_sub
        $error("hls_deadlock_monitor_gen: NUM_SUB must not exceed NUM_INST");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_err_cnt_w
        $error("hls_deadlock_monitor_gen: CNT_W must be in 1..32");
    end

    logic               raw;
    logic [CAUSE_W-1:0] cause_now;

    hls_deadlock_raw_reduce #(
        .NUM_AXIS  (NUM_AXIS),
        .AXIS_MASK (AXIS_MASK),
        .NUM_INST  (NUM_INST),
        .NUM_SUB   (NUM_SUB),
        .SUB_MODE  (SUB_MODE)
    ) u_reduce (
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .inst_block_sigs (inst_block_sigs),
        .raw             (raw),
        .cause           (cause_now)
    );

    dl_state_e        state_q, state_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d, run_cnt_inc;
    logic             enter_blk;

    assign run_cnt_inc = CNT_W'(sat_inc(32'(run_cnt_q), CNT_MAX32));

    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        enter_blk = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (raw) begin
                    run_cnt_d = CNT_W'(1);
                    if (THRESH == 1) begin
                        state_d   = ST_BLOCKED;
                        enter_blk = 1'b1;
                    end else begin
                        state_d = ST_ARMING;
                    end
                end
            end
            ST_ARMING: begin
                // Any raw-low sample restarts debouncing from scratch.
                if (!raw) begin
                    run_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    run_cnt_d = run_cnt_inc;
                    if (run_cnt_inc == THRESH_C) begin
                        state_d   = ST_BLOCKED;
                        enter_blk = 1'b1;
                    end
                end
            end
            ST_BLOCKED: begin
                if (!raw) begin
                    run_cnt_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                run_cnt_d = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            run_cnt_q    <= '0;
            block_sticky <= 1'b0;
            block_cause  <= '0;
            block_cycles <= '0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            if (enter_blk) begin
                block_cause  <= cause_now;
                block_cycles <= CNT_W'(1);
                block_sticky <= 1'b1;
            end else begin
                if (state_q == ST_BLOCKED && raw) begin
                    block_cycles <= CNT_W'(sat_inc(32'(block_cycles), CNT_MAX32));
                end
                if (clear_sticky) begin
                    block_sticky <= 1'b0;
                end
            end
        end
    end

    assign block = (state_q == ST_BLOCKED);

endmodule
